// File: rtl/bloom_filter_engine_if.sv
// Command/response bus for the Bloom filter engine; master issues commands, slave answers.
interface bloom_filter_engine_if #(
  parameter int unsigned KEY_W  = 72,
  parameter int unsigned M_LOG2 = 10
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [KEY_W-1:0]  cmd_key;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_hit;
  logic              rsp_err;
  logic [M_LOG2:0]   fill_count;

  modport master (
    output cmd_valid, cmd_op, cmd_key, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_hit, rsp_err, fill_count
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_key, rsp_ready,
    output cmd_ready, rsp_valid, rsp_hit, rsp_err, fill_count
  );
endinterface

// File: rtl/bloom_filter_engine.sv
// Bloom filter membership engine: QUERY / INSERT / CLEAR over a flop-based bit array,
// one probe per cycle with read-modify-write and a running set-bit count.
module bloom_filter_engine #(
  parameter int unsigned KEY_W    = 72,
  parameter int unsigned NUM_HASH = 3,
  parameter int unsigned M_LOG2   = 10,
  parameter int unsigned WORD_W   = 16
) (
  input logic                  clk,
  input logic                  rst,
  bloom_filter_engine_if.slave bus
);

  localparam int unsigned CHUNKS    = (KEY_W + 31) / 32;
  localparam int unsigned WORD_LOG2 = $clog2(WORD_W);
  localparam int unsigned DEPTH     = (2 ** M_LOG2) / WORD_W;
  localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned BW        = (WORD_LOG2 > 0) ? WORD_LOG2 : 1;
  localparam int unsigned IW        = 4;
  localparam int unsigned FW        = M_LOG2 + 1;

  localparam logic [1:0] OP_QUERY  = 2'b00;
  localparam logic [1:0] OP_INSERT = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HASH,
    S_PROBE,
    S_CLEAR,
    S_RESP
  } state_e;

  // Fold the key into 32 bits, mix it, and return {h2, h1} with h2 forced odd.
  function automatic logic [2*M_LOG2-1:0] key_hash(input logic [KEY_W-1:0] key);
    logic [CHUNKS*32-1:0] padded;
    logic [31:0]          a;
    logic [M_LOG2-1:0]    h1;
    logic [M_LOG2-1:0]    h2;
    padded = (CHUNKS*32)'(key);
    a      = '0;
    for (int i = 0; i < int'(CHUNKS); i++) begin
      a = a ^ padded[i*32 +: 32];
    end
    a  = a + (a << 10);
    a  = a ^ (a >> 6);
    a  = a + (a << 3);
    a  = a ^ (a >> 11);
    a  = a + (a << 15);
    h1 = a[M_LOG2-1:0];
    h2 = a[16 +: M_LOG2];
    h2[0] = 1'b1;
    return {h2, h1};
  endfunction

  state_e              state_q;
  logic [1:0]          op_q;
  logic [KEY_W-1:0]    key_q;
  logic [M_LOG2-1:0]   addr_q;
  logic [M_LOG2-1:0]   step_q;
  logic [IW-1:0]       idx_q;
  logic [AW-1:0]       clr_q;
  logic                hit_q;
  logic                cmd_ready_q;
  logic                rsp_valid_q;
  logic                rsp_hit_q;
  logic                rsp_err_q;
  logic [FW-1:0]       fill_q;
  logic [WORD_W-1:0]   mem_q [DEPTH];

  logic [2*M_LOG2-1:0] hash_c;
  logic [AW-1:0]       word_idx_c;
  logic [BW-1:0]       bit_idx_c;
  logic [WORD_W-1:0]   rd_word_c;
  logic                rd_bit_c;
  logic                hit_d;
  logic                probe_last_c;
  logic                clr_last_c;

  // Probe address decode and read of the currently addressed bit.
  always_comb begin
    hash_c       = key_hash(key_q);
    word_idx_c   = AW'(addr_q >> WORD_LOG2);
    bit_idx_c    = BW'(addr_q & M_LOG2'(WORD_W - 1));
    rd_word_c    = mem_q[word_idx_c];
    rd_bit_c     = rd_word_c[bit_idx_c];
    hit_d        = hit_q & rd_bit_c;
    probe_last_c = (idx_q == IW'(NUM_HASH - 1));
    clr_last_c   = (clr_q == AW'(DEPTH - 1));
  end

  // Control FSM, bit-array storage and occupancy counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      op_q        <= OP_QUERY;
      key_q       <= '0;
      addr_q      <= '0;
      step_q      <= '0;
      idx_q       <= '0;
      clr_q       <= '0;
      hit_q       <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      fill_q      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid && cmd_ready_q) begin
            op_q        <= bus.cmd_op;
            key_q       <= bus.cmd_key;
            cmd_ready_q <= 1'b0;
            state_q     <= S_HASH;
          end
        end
        S_HASH: begin
          addr_q <= hash_c[M_LOG2-1:0];
          step_q <= hash_c[2*M_LOG2-1:M_LOG2];
          idx_q  <= '0;
          clr_q  <= '0;
          hit_q  <= 1'b1;
          case (op_q)
            OP_QUERY, OP_INSERT: state_q <= S_PROBE;
            OP_CLEAR:            state_q <= S_CLEAR;
            default: begin
              rsp_valid_q <= 1'b1;
              rsp_hit_q   <= 1'b0;
              rsp_err_q   <= 1'b1;
              state_q     <= S_RESP;
            end
          endcase
        end
        S_PROBE: begin
          hit_q  <= hit_d;
          addr_q <= addr_q + step_q;
          idx_q  <= idx_q + IW'(1);
          // The write lands this cycle, so the next probe already sees it.
          if ((op_q == OP_INSERT) && !rd_bit_c) begin
            mem_q[word_idx_c][bit_idx_c] <= 1'b1;
            fill_q                       <= fill_q + FW'(1);
          end
          if (probe_last_c) begin
            rsp_valid_q <= 1'b1;
            rsp_hit_q   <= hit_d;
            rsp_err_q   <= 1'b0;
            state_q     <= S_RESP;
          end
        end
        S_CLEAR: begin
          mem_q[clr_q] <= '0;
          clr_q        <= clr_q + AW'(1);
          if (clr_last_c) begin
            fill_q      <= '0;
            rsp_valid_q <= 1'b1;
            rsp_hit_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
            state_q     <= S_RESP;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_hit    = rsp_hit_q;
  assign bus.rsp_err    = rsp_err_q;
  assign bus.fill_count = fill_q;

endmodule

// File: tb/tb_bloom_filter_engine.sv
// Directed and model-based checks for bloom_filter_engine at default parameters.
module tb_bloom_filter_engine;

  localparam int unsigned KEY_W = 72;
  localparam int unsigned M_LOG2 = 10;
  localparam int unsigned NBITS = 1024;
  localparam logic [71:0] K1 = 72'hC0A80001_0A000001_06;
  localparam logic [71:0] K2 = 72'hC0A80002_0A000001_11;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  bloom_filter_engine_if #(.KEY_W(KEY_W), .M_LOG2(M_LOG2)) bus ();

  bloom_filter_engine #(
    .KEY_W(KEY_W), .NUM_HASH(3), .M_LOG2(M_LOG2), .WORD_W(16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  bit         ref_arr [NBITS];
  int         ref_fill;
  logic [KEY_W-1:0] pool [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic [1:0] op);
    if (op == 2'b10) return 66;
    if (op == 2'b11) return 2;
    return 5;
  endfunction

  // Reference: returns expected hit and updates the model array for INSERT/CLEAR.
  function automatic bit ref_apply(input logic [1:0] op, input logic [71:0] k);
    bit [31:0] f;
    bit [31:0] a;
    int h1;
    int h2;
    int p;
    bit hit;
    if (op == 2'b10) begin
      for (int i = 0; i < int'(NBITS); i++) ref_arr[i] = 1'b0;
      ref_fill = 0;
      return 1'b0;
    end
    if (op == 2'b11) return 1'b0;
    f = k[31:0] ^ k[63:32] ^ {24'h0, k[71:64]};
    a = f + (f << 10);
    a = a ^ (a >> 6);
    a = a + (a << 3);
    a = a ^ (a >> 11);
    a = a + (a << 15);
    h1 = int'(a & 32'h3FF);
    h2 = int'((a >> 16) & 32'h3FF) | 1;
    hit = 1'b1;
    for (int i = 0; i < 3; i++) begin
      p = (h1 + i * h2) % 1024;
      hit = hit & ref_arr[p];
      if (op == 2'b01 && !ref_arr[p]) begin
        ref_arr[p] = 1'b1;
        ref_fill++;
      end
    end
    return hit;
  endfunction

  // Issue one command, wait for its response, optionally backpressure, then consume it.
  task automatic do_cmd(input logic [1:0] op, input logic [71:0] key, input logic exp_hit,
                        input logic exp_err, input int hold, input string tag);
    int  c0;
    bit  seen;
    @(negedge clk);
    check({tag, "_ready_idle"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_key   = key;
    c0 = cyc;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_key   = '0;
    check({tag, "_ready_drop"}, 32'(bus.cmd_ready), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (bus.rsp_valid) seen = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_rsp_seen"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(cyc - c0), 32'(exp_latency(op)));
    check({tag, "_hit"}, 32'(bus.rsp_hit), 32'(exp_hit));
    check({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_bp_valid"}, 32'(bus.rsp_valid), 32'd1);
      check({tag, "_bp_hit"}, 32'(bus.rsp_hit), 32'(exp_hit));
      check({tag, "_bp_ready"}, 32'(bus.cmd_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
    check({tag, "_ready_back"}, 32'(bus.cmd_ready), 32'd1);
  endtask

  initial begin
    logic [10:0]      fill_before;
    logic [1:0]       rop;
    logic [KEY_W-1:0] rkey;
    bit               rhit;
    int               r;

    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst   = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'b00;
    bus.cmd_key   = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("reset_rsp_hit", 32'(bus.rsp_hit), 32'd0);
    check("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
    check("reset_fill", 32'(bus.fill_count), 32'd0);

    // Empty filter: QUERY misses
    do_cmd(2'b00, K1, 1'b0, 1'b0, 0, "q_empty");
    check("q_empty_fill", 32'(bus.fill_count), 32'd0);

    // Odd probe stride guarantees three distinct bits for one key
    do_cmd(2'b01, K1, 1'b0, 1'b0, 0, "ins1");
    check("ins1_fill", 32'(bus.fill_count), 32'd3);
    do_cmd(2'b01, K1, 1'b1, 1'b0, 0, "ins1_dup");
    check("ins1_dup_fill", 32'(bus.fill_count), 32'd3);
    do_cmd(2'b00, K1, 1'b1, 1'b0, 0, "q_k1");

    // Backpressure: response held for 10 cycles
    do_cmd(2'b00, K1, 1'b1, 1'b0, 10, "q_bp");
    check("q_bp_fill", 32'(bus.fill_count), 32'd3);

    // Insert both keys, then wipe the array
    do_cmd(2'b01, K1, 1'b1, 1'b0, 0, "ins_k1b");
    do_cmd(2'b01, K2, 1'b0, 1'b0, 0, "ins_k2");
    do_cmd(2'b00, K2, 1'b1, 1'b0, 0, "q_k2");
    do_cmd(2'b10, '0, 1'b0, 1'b0, 0, "clear");
    check("clear_fill", 32'(bus.fill_count), 32'd0);
    do_cmd(2'b00, K1, 1'b0, 1'b0, 0, "q_k1_clr");
    do_cmd(2'b00, K2, 1'b0, 1'b0, 0, "q_k2_clr");

    // Illegal opcode leaves the array alone
    do_cmd(2'b01, K1, 1'b0, 1'b0, 0, "ins_pre_ill");
    fill_before = bus.fill_count;
    check("pre_ill_fill", 32'(fill_before), 32'd3);
    do_cmd(2'b11, K1, 1'b0, 1'b1, 0, "illegal");
    check("ill_fill", 32'(bus.fill_count), 32'(fill_before));
    do_cmd(2'b00, K1, 1'b1, 1'b0, 0, "q_after_ill");
    do_cmd(2'b10, '0, 1'b0, 1'b0, 0, "clear2");

    // Reset during the second probe of an INSERT
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'b01;
    bus.cmd_key   = K1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_fill", 32'(bus.fill_count), 32'd0);
    check("rst_mid_valid", 32'(bus.rsp_valid), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    check("rst_after_fill", 32'(bus.fill_count), 32'd0);
    do_cmd(2'b00, K1, 1'b0, 1'b0, 0, "q_after_rst");

    // Random ops against the reference model; small key pool forces repeats
    for (int i = 0; i < int'(NBITS); i++) ref_arr[i] = 1'b0;
    ref_fill = 0;
    for (int i = 0; i < 16; i++) pool[i] = KEY_W'({$urandom, $urandom, $urandom});
    pool[0] = K1;
    pool[1] = K2;
    for (int n = 0; n < 2000; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 2)       rop = 2'b10;
      else if (r < 5)  rop = 2'b11;
      else if (r < 55) rop = 2'b01;
      else             rop = 2'b00;
      rkey = ($urandom_range(0, 3) == 0) ? KEY_W'({$urandom, $urandom, $urandom})
                                         : pool[$urandom_range(0, 15)];
      rhit = ref_apply(rop, rkey);
      do_cmd(rop, rkey, rhit, (rop == 2'b11), 0, "rand");
      check("rand_fill", 32'(bus.fill_count), 32'(ref_fill));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
